// File: rtl/reg_window_spill_ctrl_if.sv
// Handshake and bus bundle between the window controller, the control FSM,
// the register file maintenance port and the spill memory.
interface reg_window_spill_ctrl_if #(
  parameter int NSLOT = 8,
  parameter int CNT_W = 8
);
  localparam int PW = $clog2(NSLOT);
  localparam int AW = PW + 2;

  logic             call_req;
  logic             ret_req;
  logic             busy;
  logic             done;
  logic             err;
  logic [1:0]       winAddSub;
  logic [PW-1:0]    cwp;
  logic [PW-1:0]    resident;
  logic [CNT_W-1:0] spill_cnt;
  logic [AW-1:0]    phys_raddr;
  logic [15:0]      phys_rdata;
  logic             phys_we;
  logic [AW-1:0]    phys_waddr;
  logic [15:0]      phys_wdata;
  logic             mem_req;
  logic             mem_we;
  logic [15:0]      mem_addr;
  logic [15:0]      mem_wdata;
  logic             mem_ack;
  logic [15:0]      mem_rdata;

  // Controller side
  modport master (
    input  call_req, ret_req, phys_rdata, mem_ack, mem_rdata,
    output busy, done, err, winAddSub, cwp, resident, spill_cnt,
           phys_raddr, phys_we, phys_waddr, phys_wdata,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  // Environment side (control FSM, register file, memory)
  modport slave (
    output call_req, ret_req, phys_rdata, mem_ack, mem_rdata,
    input  busy, done, err, winAddSub, cwp, resident, spill_cnt,
           phys_raddr, phys_we, phys_waddr, phys_wdata,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/reg_window_spill_ctrl.sv
// Register-window controller: turns call/return requests into window shifts,
// spilling the oldest 4-register slot to a memory stack when the physical
// file is full and filling it back when a return reaches a non-resident slot.
module reg_window_spill_ctrl #(
  parameter int          NSLOT      = 8,
  parameter logic [15:0] STACK_BASE = 16'hF000,
  parameter int          CNT_W      = 8
) (
  input logic                     clock,
  input logic                     reset,
  reg_window_spill_ctrl_if.master bus
);
  localparam int PW = $clog2(NSLOT);
  localparam int AW = PW + 2;

  localparam logic [PW-1:0]    RES_MAX  = PW'(NSLOT - 2);
  localparam logic [PW-1:0]    SLOT_ONE = PW'(1);
  localparam logic [PW-1:0]    SLOT_ZER = PW'(0);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZER  = CNT_W'(0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SPILL  = 2'd1,
    FILL   = 2'd2,
    COMMIT = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       k_q, k_d;
  logic [PW-1:0]    slot_q, slot_d;          // oldest slot (spill) or target slot (fill)
  logic             dir_q, dir_d;            // 1 = call, 0 = return
  logic [15:0]      spill_ptr_q, spill_ptr_d;
  logic [PW-1:0]    cwp_q, cwp_d;
  logic [PW-1:0]    resident_q, resident_d;
  logic [CNT_W-1:0] spill_cnt_q, spill_cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [1:0]       was_q, was_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic [15:0]      mem_addr_q, mem_addr_d;
  logic [AW-1:0]    phys_raddr_q, phys_raddr_d;
  logic             fill_ack_s;

  // Next-state, counter and registered-output computation
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    slot_d      = slot_q;
    dir_d       = dir_q;
    spill_ptr_d = spill_ptr_q;
    cwp_d       = cwp_q;
    resident_d  = resident_q;
    spill_cnt_d = spill_cnt_q;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (err_q) begin
          // The requester still holds a just-rejected request this cycle;
          // ignore it so one bad request yields exactly one err pulse.
          state_d = IDLE;
        end else if (bus.call_req && bus.ret_req) begin
          err_d = 1'b1;
        end else if (bus.call_req) begin
          dir_d = 1'b1;
          if (resident_q < RES_MAX) begin
            state_d = COMMIT;
          end else if (spill_cnt_q == CNT_MAX) begin
            err_d = 1'b1;
          end else begin
            state_d = SPILL;
            k_d     = 2'd0;
            slot_d  = cwp_q - resident_q;
          end
        end else if (bus.ret_req) begin
          dir_d = 1'b0;
          if (resident_q != SLOT_ZER) begin
            state_d = COMMIT;
          end else if (spill_cnt_q == CNT_ZER) begin
            err_d = 1'b1;
          end else begin
            state_d = FILL;
            k_d     = 2'd0;
            slot_d  = cwp_q - SLOT_ONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SPILL: begin
        if (bus.mem_ack) begin
          k_d = k_q + 2'd1;
          if (k_q == 2'd3) begin
            spill_ptr_d = spill_ptr_q + 16'd4;
            spill_cnt_d = spill_cnt_q + CNT_ONE;
            resident_d  = resident_q - SLOT_ONE;
            state_d     = COMMIT;
          end else begin
            state_d = SPILL;
          end
        end else begin
          state_d = SPILL;
        end
      end
      FILL: begin
        if (bus.mem_ack) begin
          k_d = k_q + 2'd1;
          if (k_q == 2'd3) begin
            spill_ptr_d = spill_ptr_q - 16'd4;
            spill_cnt_d = spill_cnt_q - CNT_ONE;
            resident_d  = resident_q + SLOT_ONE;
            state_d     = COMMIT;
          end else begin
            state_d = FILL;
          end
        end else begin
          state_d = FILL;
        end
      end
      COMMIT: begin
        if (dir_q) begin
          cwp_d      = cwp_q + SLOT_ONE;
          resident_d = resident_q + SLOT_ONE;
        end else begin
          cwp_d      = cwp_q - SLOT_ONE;
          resident_d = resident_q - SLOT_ONE;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered: derive them from the state being entered.
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == COMMIT);
    mem_req_d = (state_d == SPILL) || (state_d == FILL);
    mem_we_d  = (state_d == SPILL);
    if (state_d == COMMIT) begin
      was_d = dir_d ? 2'b10 : 2'b01;
    end else begin
      was_d = 2'b00;
    end
    case (state_d)
      SPILL: begin
        mem_addr_d   = spill_ptr_d + {14'd0, k_d};
        phys_raddr_d = {slot_d, k_d};
      end
      FILL: begin
        mem_addr_d   = spill_ptr_d - 16'd4 + {14'd0, k_d};
        phys_raddr_d = {AW{1'b0}};
      end
      default: begin
        mem_addr_d   = 16'd0;
        phys_raddr_d = {AW{1'b0}};
      end
    endcase
  end

  // State and registered-output flops with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      k_q          <= 2'd0;
      slot_q       <= {PW{1'b0}};
      dir_q        <= 1'b0;
      spill_ptr_q  <= STACK_BASE;
      cwp_q        <= {PW{1'b0}};
      resident_q   <= {PW{1'b0}};
      spill_cnt_q  <= {CNT_W{1'b0}};
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      was_q        <= 2'b00;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 16'd0;
      phys_raddr_q <= {AW{1'b0}};
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      slot_q       <= slot_d;
      dir_q        <= dir_d;
      spill_ptr_q  <= spill_ptr_d;
      cwp_q        <= cwp_d;
      resident_q   <= resident_d;
      spill_cnt_q  <= spill_cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      was_q        <= was_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      phys_raddr_q <= phys_raddr_d;
    end
  end

  // Spill write data is the combinational read of the slot word being moved;
  // fill writes land in the register file in the same cycle the memory acks.
  assign fill_ack_s     = (state_q == FILL) && bus.mem_ack;
  assign bus.mem_wdata  = (state_q == SPILL) ? bus.phys_rdata : 16'd0;
  assign bus.phys_we    = fill_ack_s;
  assign bus.phys_waddr = fill_ack_s ? {slot_q, k_q} : {AW{1'b0}};
  assign bus.phys_wdata = fill_ack_s ? bus.mem_rdata : 16'd0;

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.winAddSub  = was_q;
  assign bus.cwp        = cwp_q;
  assign bus.resident   = resident_q;
  assign bus.spill_cnt  = spill_cnt_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.phys_raddr = phys_raddr_q;
endmodule

// File: tb/tb_reg_window_spill_ctrl.sv
// Self-checking bench for reg_window_spill_ctrl: directed scenarios plus a
// randomized call/return walk checked against a window/stack model.
module tb_reg_window_spill_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b1;

  reg_window_spill_ctrl_if bus ();

  reg_window_spill_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Register file and memory behaviour owned by the bench
  logic [15:0] phys    [0:31];
  logic [15:0] ext_mem [0:65535];
  logic [15:0] wr_addr[$];
  logic [15:0] wr_data[$];
  logic [15:0] rd_addr[$];
  int          wait_cycles = 0;
  int          wcnt = 0;
  logic [15:0] lat_addr;
  logic [15:0] lat_wd;
  logic        lat_we;
  int          stab_err = 0;
  int          req_cycles = 0;
  int          bad_was = 0;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int          m_cwp, m_res, m_cnt, m_ptr;
  logic [15:0] m_stack[$];

  assign bus.phys_rdata = phys[bus.phys_raddr];

  // Register file write port
  always @(posedge clock) begin
    if (bus.phys_we === 1'b1) phys[bus.phys_waddr] = bus.phys_wdata;
  end

  // Memory responder with programmable wait states and request-stability tracking
  always @(negedge clock) begin
    if (bus.mem_req === 1'b1 && !reset) begin
      req_cycles++;
      if (wcnt == 0) begin
        lat_addr = bus.mem_addr; lat_we = bus.mem_we; lat_wd = bus.mem_wdata;
      end else if (bus.mem_addr !== lat_addr || bus.mem_we !== lat_we ||
                   (lat_we && bus.mem_wdata !== lat_wd)) begin
        stab_err++;
      end
      if (wcnt >= wait_cycles) begin
        bus.mem_ack = 1'b1;
        if (bus.mem_we) begin
          ext_mem[bus.mem_addr] = bus.mem_wdata;
          wr_addr.push_back(bus.mem_addr);
          wr_data.push_back(bus.mem_wdata);
          bus.mem_rdata = 16'h0000;
        end else begin
          bus.mem_rdata = ext_mem[bus.mem_addr];
          rd_addr.push_back(bus.mem_addr);
        end
        wcnt = 0;
      end else begin
        bus.mem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      if (wcnt > 0 && !reset) stab_err++;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 16'h0000;
      wcnt = 0;
    end
  end

  // winAddSub must only be nonzero alongside done
  always @(negedge clock) begin
    if (!reset && bus.winAddSub !== 2'b00 && bus.done !== 1'b1) bad_was++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    m_cwp = 0; m_res = 0; m_cnt = 0; m_ptr = 16'hF000;
    m_stack.delete();
    wr_addr.delete(); wr_data.delete(); rd_addr.delete();
  endtask

  // Issue one request, drop it after the sample edge, and wait for done/err
  task automatic do_op(input logic c, input logic r, output int lat,
                       output logic got_done, output logic got_err, output logic [1:0] wa);
    @(negedge clock);
    bus.call_req = c; bus.ret_req = r;
    @(posedge clock); #1;
    bus.call_req = 1'b0; bus.ret_req = 1'b0;
    lat = 1; got_done = 1'b0; got_err = 1'b0; wa = 2'b11;
    while (lat < 200) begin
      if (bus.done === 1'b1) begin got_done = 1'b1; wa = bus.winAddSub; break; end
      if (bus.err === 1'b1) begin got_err = 1'b1; wa = bus.winAddSub; break; end
      if (bus.busy !== 1'b1) break;
      @(posedge clock); #1;
      lat++;
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_checks++;
    if ({bus.busy, bus.done, bus.err, bus.mem_req, bus.mem_we, bus.phys_we} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 000000",
        {bus.busy, bus.done, bus.err, bus.mem_req, bus.mem_we, bus.phys_we});
    end
    n_checks++;
    if ({bus.winAddSub, bus.cwp, bus.resident, bus.spill_cnt} !== 16'h0000) begin
      n_fail++; $display("FAIL reset_state: was=%b cwp=%0d res=%0d cnt=%0d want all 0",
        bus.winAddSub, bus.cwp, bus.resident, bus.spill_cnt);
    end
    n_checks++;
    if ({bus.phys_raddr, bus.phys_waddr, bus.mem_addr, bus.mem_wdata, bus.phys_wdata} !== 58'd0) begin
      n_fail++; $display("FAIL reset_addr: raddr=%h waddr=%h maddr=%h mwd=%h pwd=%h want 0",
        bus.phys_raddr, bus.phys_waddr, bus.mem_addr, bus.mem_wdata, bus.phys_wdata);
    end
    n_checks++;
    if (dut.spill_ptr_q !== 16'hF000 || dut.k_q !== 2'd0) begin
      n_fail++; $display("FAIL reset_ptr: spill_ptr=%h k=%0d want F000 0", dut.spill_ptr_q, dut.k_q);
    end
  endtask

  task automatic test_calls_no_spill();
    int lat; logic d, e; logic [1:0] wa;
    int req0 = req_cycles;
    for (int i = 0; i < 6; i++) begin
      do_op(1'b1, 1'b0, lat, d, e, wa);
      n_checks++;
      if (d !== 1'b1 || lat != 1 || wa !== 2'b10) begin
        n_fail++; $display("FAIL call_commit[%0d]: done=%b lat=%0d was=%b want 1 1 10", i, d, lat, wa);
      end
      n_checks++;
      if (bus.cwp !== 3'(i + 1) || bus.resident !== 3'(i + 1)) begin
        n_fail++; $display("FAIL call_state[%0d]: cwp=%0d res=%0d want %0d", i, bus.cwp, bus.resident, i + 1);
      end
    end
    n_checks++;
    if (req_cycles != req0) begin
      n_fail++; $display("FAIL call_nomem: mem_req cycles=%0d want %0d", req_cycles, req0);
    end
  endtask

  task automatic test_spill_call(input logic [15:0] exp_lat, input int w);
    int lat; logic d, e; logic [1:0] wa;
    logic [15:0] pre [4];
    for (int i = 0; i < 4; i++) begin
      pre[i] = (w == 0) ? 16'h1111 * 16'(i + 1) : 16'($urandom);
      phys[i] = pre[i];
    end
    wr_addr.delete(); wr_data.delete();
    stab_err = 0;
    wait_cycles = w;
    do_op(1'b1, 1'b0, lat, d, e, wa);
    n_checks++;
    if (d !== 1'b1 || lat != int'(exp_lat) || wa !== 2'b10) begin
      n_fail++; $display("FAIL spill_done: done=%b lat=%0d was=%b want 1 %0d 10", d, lat, wa, exp_lat);
    end
    n_checks++;
    if (wr_addr.size() != 4) begin
      n_fail++; $display("FAIL spill_count: writes=%0d want 4", wr_addr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (wr_addr[i] !== 16'hF000 + 16'(i) || wr_data[i] !== pre[i]) begin
          n_fail++; $display("FAIL spill_word[%0d]: addr=%h data=%h want %h %h",
            i, wr_addr[i], wr_data[i], 16'hF000 + 16'(i), pre[i]);
        end
      end
    end
    n_checks++;
    if (bus.cwp !== 3'd7 || bus.resident !== 3'd6 || bus.spill_cnt !== 8'd1 || dut.spill_ptr_q !== 16'hF004) begin
      n_fail++; $display("FAIL spill_state: cwp=%0d res=%0d cnt=%0d ptr=%h want 7 6 1 F004",
        bus.cwp, bus.resident, bus.spill_cnt, dut.spill_ptr_q);
    end
    n_checks++;
    if (stab_err != 0) begin
      n_fail++; $display("FAIL spill_stable: unstable request cycles=%0d want 0", stab_err);
    end
    wait_cycles = 0;
  endtask

  task automatic test_returns_fill(input logic [15:0] exp_lat, input int w);
    int lat; logic d, e; logic [1:0] wa;
    logic [15:0] pre [4];
    for (int i = 0; i < 4; i++) pre[i] = phys[i];
    for (int i = 0; i < 6; i++) begin
      do_op(1'b0, 1'b1, lat, d, e, wa);
      n_checks++;
      if (d !== 1'b1 || lat != 1 || wa !== 2'b01) begin
        n_fail++; $display("FAIL ret_commit[%0d]: done=%b lat=%0d was=%b want 1 1 01", i, d, lat, wa);
      end
    end
    n_checks++;
    if (bus.cwp !== 3'd1 || bus.resident !== 3'd0) begin
      n_fail++; $display("FAIL ret_state: cwp=%0d res=%0d want 1 0", bus.cwp, bus.resident);
    end
    for (int i = 0; i < 4; i++) phys[i] = 16'h0000;
    rd_addr.delete();
    stab_err = 0;
    wait_cycles = w;
    do_op(1'b0, 1'b1, lat, d, e, wa);
    n_checks++;
    if (d !== 1'b1 || lat != int'(exp_lat) || wa !== 2'b01) begin
      n_fail++; $display("FAIL fill_done: done=%b lat=%0d was=%b want 1 %0d 01", d, lat, wa, exp_lat);
    end
    n_checks++;
    if (rd_addr.size() != 4) begin
      n_fail++; $display("FAIL fill_count: reads=%0d want 4", rd_addr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (rd_addr[i] !== 16'hF000 + 16'(i) || phys[i] !== pre[i]) begin
          n_fail++; $display("FAIL fill_word[%0d]: addr=%h phys=%h want %h %h",
            i, rd_addr[i], phys[i], 16'hF000 + 16'(i), pre[i]);
        end
      end
    end
    n_checks++;
    if (bus.cwp !== 3'd0 || bus.resident !== 3'd0 || bus.spill_cnt !== 8'd0 || dut.spill_ptr_q !== 16'hF000) begin
      n_fail++; $display("FAIL fill_state: cwp=%0d res=%0d cnt=%0d ptr=%h want 0 0 0 F000",
        bus.cwp, bus.resident, bus.spill_cnt, dut.spill_ptr_q);
    end
    n_checks++;
    if (stab_err != 0) begin
      n_fail++; $display("FAIL fill_stable: unstable request cycles=%0d want 0", stab_err);
    end
    wait_cycles = 0;
  endtask

  task automatic test_underflow();
    int lat; logic d, e; logic [1:0] wa;
    int req0 = req_cycles;
    do_op(1'b0, 1'b1, lat, d, e, wa);
    n_checks++;
    if (e !== 1'b1 || d !== 1'b0 || lat != 1 || wa !== 2'b00) begin
      n_fail++; $display("FAIL underflow_err: err=%b done=%b lat=%0d was=%b want 1 0 1 00", e, d, lat, wa);
    end
    n_checks++;
    if (bus.cwp !== 3'd0 || bus.resident !== 3'd0 || bus.spill_cnt !== 8'd0 || req_cycles != req0) begin
      n_fail++; $display("FAIL underflow_state: cwp=%0d res=%0d cnt=%0d memreq=%0d want 0 0 0 0",
        bus.cwp, bus.resident, bus.spill_cnt, req_cycles - req0);
    end
  endtask

  task automatic test_both_requests();
    int lat; logic d, e; logic [1:0] wa;
    do_op(1'b1, 1'b0, lat, d, e, wa);
    do_op(1'b1, 1'b1, lat, d, e, wa);
    n_checks++;
    if (e !== 1'b1 || d !== 1'b0 || lat != 1 || wa !== 2'b00) begin
      n_fail++; $display("FAIL both_err: err=%b done=%b lat=%0d was=%b want 1 0 1 00", e, d, lat, wa);
    end
    n_checks++;
    if (bus.cwp !== 3'd1 || bus.resident !== 3'd1 || bus.err !== 1'b0) begin
      n_fail++; $display("FAIL both_state: cwp=%0d res=%0d err=%b want 1 1 0", bus.cwp, bus.resident, bus.err);
    end
    do_op(1'b0, 1'b1, lat, d, e, wa);
    n_checks++;
    if (d !== 1'b1 || bus.cwp !== 3'd0 || bus.resident !== 3'd0) begin
      n_fail++; $display("FAIL both_recover: done=%b cwp=%0d res=%0d want 1 0 0", d, bus.cwp, bus.resident);
    end
  endtask

  task automatic test_reset_mid_spill();
    int lat; logic d, e; logic [1:0] wa;
    for (int i = 0; i < 6; i++) do_op(1'b1, 1'b0, lat, d, e, wa);
    @(negedge clock);
    bus.call_req = 1'b1;
    @(posedge clock); #1;
    bus.call_req = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    n_checks++;
    if (dut.k_q !== 2'd2 || bus.mem_req !== 1'b1) begin
      n_fail++; $display("FAIL midspill_pos: k=%0d mem_req=%b want 2 1", dut.k_q, bus.mem_req);
    end
    reset = 1'b1;
    @(posedge clock); #1;
    n_checks++;
    if (bus.mem_req !== 1'b0 || bus.busy !== 1'b0 || bus.phys_we !== 1'b0) begin
      n_fail++; $display("FAIL midspill_ctrl: mem_req=%b busy=%b phys_we=%b want 0 0 0",
        bus.mem_req, bus.busy, bus.phys_we);
    end
    n_checks++;
    if (bus.cwp !== 3'd0 || bus.resident !== 3'd0 || bus.spill_cnt !== 8'd0 ||
        dut.spill_ptr_q !== 16'hF000 || dut.k_q !== 2'd0) begin
      n_fail++; $display("FAIL midspill_state: cwp=%0d res=%0d cnt=%0d ptr=%h k=%0d want 0 0 0 F000 0",
        bus.cwp, bus.resident, bus.spill_cnt, dut.spill_ptr_q, dut.k_q);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_random_walk();
    int lat; logic d, e; logic [1:0] wa;
    apply_reset();
    stab_err = 0;
    bad_was = 0;
    for (int n = 0; n < 80; n++) begin
      int pick = $urandom_range(0, 99);
      int w = $urandom_range(0, 2);
      logic c, r;
      int kind;                // 0 commit only, 1 spill, 2 fill, 3 error
      int slot;
      int exp_lat;
      logic [15:0] exp_d [4];
      logic [15:0] exp_a [4];
      if (pick < 8) begin c = 1'b1; r = 1'b1; end
      else if ((n < 40) ? (pick < 78) : (pick < 30)) begin c = 1'b1; r = 1'b0; end
      else begin c = 1'b0; r = 1'b1; end
      for (int i = 0; i < 32; i++) phys[i] = 16'($urandom);
      slot = 0;
      if (c && r) kind = 3;
      else if (c) kind = (m_res < 6) ? 0 : ((m_cnt == 255) ? 3 : 1);
      else kind = (m_res > 0) ? 0 : ((m_cnt == 0) ? 3 : 2);
      if (kind == 1) begin
        slot = (m_cwp - m_res + 8) % 8;
        for (int i = 0; i < 4; i++) begin
          exp_a[i] = 16'(m_ptr + i);
          exp_d[i] = phys[slot * 4 + i];
          m_stack.push_back(exp_d[i]);
        end
        m_ptr += 4; m_cnt++; m_res--;
      end else if (kind == 2) begin
        slot = (m_cwp + 7) % 8;
        for (int i = 0; i < 4; i++) begin
          exp_a[i] = 16'(m_ptr - 4 + i);
          exp_d[i] = m_stack[m_stack.size() - 4 + i];
        end
        repeat (4) void'(m_stack.pop_back());
        m_ptr -= 4; m_cnt--; m_res++;
      end
      if (kind != 3) begin
        m_cwp = c ? (m_cwp + 1) % 8 : (m_cwp + 7) % 8;
        m_res = c ? m_res + 1 : m_res - 1;
      end
      exp_lat = (kind == 1 || kind == 2) ? 4 * (w + 1) + 1 : 1;
      wait_cycles = w;
      wr_addr.delete(); wr_data.delete(); rd_addr.delete();
      do_op(c, r, lat, d, e, wa);
      n_checks++;
      if (d !== (kind != 3) || e !== (kind == 3) || lat != exp_lat) begin
        n_fail++; $display("FAIL rnd_outcome[%0d]: done=%b err=%b lat=%0d want kind=%0d lat=%0d",
          n, d, e, lat, kind, exp_lat);
      end
      n_checks++;
      if (wa !== ((kind == 3) ? 2'b00 : (c ? 2'b10 : 2'b01))) begin
        n_fail++; $display("FAIL rnd_was[%0d]: was=%b kind=%0d call=%b", n, wa, kind, c);
      end
      n_checks++;
      if (bus.cwp !== 3'(m_cwp) || bus.resident !== 3'(m_res) || bus.spill_cnt !== 8'(m_cnt)) begin
        n_fail++; $display("FAIL rnd_state[%0d]: cwp=%0d res=%0d cnt=%0d want %0d %0d %0d",
          n, bus.cwp, bus.resident, bus.spill_cnt, m_cwp, m_res, m_cnt);
      end
      if (kind == 1) begin
        n_checks++;
        if (wr_addr.size() != 4 || rd_addr.size() != 0) begin
          n_fail++; $display("FAIL rnd_spill_cnt[%0d]: writes=%0d reads=%0d want 4 0", n, wr_addr.size(), rd_addr.size());
        end else begin
          for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (wr_addr[i] !== exp_a[i] || wr_data[i] !== exp_d[i]) begin
              n_fail++; $display("FAIL rnd_spill[%0d.%0d]: addr=%h data=%h want %h %h",
                n, i, wr_addr[i], wr_data[i], exp_a[i], exp_d[i]);
            end
          end
        end
      end else if (kind == 2) begin
        n_checks++;
        if (rd_addr.size() != 4 || wr_addr.size() != 0) begin
          n_fail++; $display("FAIL rnd_fill_cnt[%0d]: reads=%0d writes=%0d want 4 0", n, rd_addr.size(), wr_addr.size());
        end else begin
          for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rd_addr[i] !== exp_a[i] || phys[slot * 4 + i] !== exp_d[i]) begin
              n_fail++; $display("FAIL rnd_fill[%0d.%0d]: addr=%h phys=%h want %h %h",
                n, i, rd_addr[i], phys[slot * 4 + i], exp_a[i], exp_d[i]);
            end
          end
        end
      end else begin
        n_checks++;
        if (wr_addr.size() != 0 || rd_addr.size() != 0) begin
          n_fail++; $display("FAIL rnd_nomem[%0d]: writes=%0d reads=%0d want 0 0", n, wr_addr.size(), rd_addr.size());
        end
      end
    end
    wait_cycles = 0;
    n_checks++;
    if (stab_err != 0 || bad_was != 0) begin
      n_fail++; $display("FAIL rnd_protocol: unstable=%0d stray_winAddSub=%0d want 0 0", stab_err, bad_was);
    end
  endtask

  initial begin
    bus.call_req = 1'b0;
    bus.ret_req  = 1'b0;
    for (int i = 0; i < 32; i++) phys[i] = 16'h0000;
    test_reset();
    test_calls_no_spill();
    test_spill_call(16'd5, 0);
    test_returns_fill(16'd5, 0);
    test_underflow();
    test_both_requests();
    test_calls_no_spill();
    test_spill_call(16'd17, 3);
    test_returns_fill(16'd17, 3);
    test_reset_mid_spill();
    n_checks++;
    if (bad_was != 0) begin
      n_fail++; $display("FAIL stray_winAddSub: cycles=%0d want 0", bad_was);
    end
    test_random_walk();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_window_spill_ctrl.md
# reg_window_spill_ctrl

Window-management stage directly upstream of `reg_file`. It is the only driver of the register file's `winAddSub` input. It turns call/return requests from the control FSM into window shifts. When the 32 physical registers are exhausted, it spills the oldest 4-register slot to a memory stack before the shift. When a return reaches a window that is no longer resident, it fills that slot back from memory before the shift.

## Interface
Parameters:
- `NSLOT`, 8: number of 4-register slots in the physical file (32/4); window pointer width is log2(NSLOT).
- `STACK_BASE`, 16'hF000: word address of the first spill entry; the stack grows upward.
- `CNT_W`, 8: width of the spilled-slot counter.

Ports:
- `clock` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `call_req` in 1: request a window advance (call); sampled only when `busy`=0.
- `ret_req` in 1: request a window retreat (return); sampled only when `busy`=0.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse in the COMMIT cycle.
- `err` out 1: one-cycle pulse on a rejected request.
- `winAddSub` out 2: to `reg_file`. 2'b10 = index+4, 2'b01 = index-4, 2'b00 = hold.
- `cwp` out 3: current window slot; `reg_file` index = `cwp`*4.
- `resident` out 3: live caller slots held in the file below `cwp` (0..NSLOT-2).
- `spill_cnt` out CNT_W: slots currently in memory.
- `phys_raddr` out 5: physical read address into `reg_file` maintenance port. Read is combinational.
- `phys_rdata` in 16: data for `phys_raddr`.
- `phys_we` out 1: physical write enable. Written at the clock edge.
- `phys_waddr` out 5, `phys_wdata` out 16: physical write address and data.
- `mem_req` out 1: memory request, held until acknowledged.
- `mem_we` out 1: 1 = write (spill), 0 = read (fill).
- `mem_addr` out 16, `mem_wdata` out 16: memory address and write data.
- `mem_ack` in 1: memory acknowledge.
- `mem_rdata` in 16: read data, valid in the `mem_ack` cycle.

## Operation
- States: IDLE, SPILL, FILL, COMMIT. Internal state:
  - word counter `k` (0..3);
  - `spill_ptr` (16b, reset `STACK_BASE`);
  - direction flag.
- All slot arithmetic is modulo NSLOT (3b wrap, 7+1=0). Physical address = slot*4+`k` (5b, wraps mod 32).
- IDLE, `call_req` only:
  - if `resident`<NSLOT-2, go to COMMIT;
  - else if `spill_cnt`=2^CNT_W-1, `err` and stay IDLE;
  - else go to SPILL with `k`=0, oldest slot = `cwp`-`resident`.
- IDLE, `ret_req` only:
  - if `resident`>0, go to COMMIT;
  - else if `spill_cnt`=0 (underflow), `err` and stay IDLE;
  - else go to FILL with `k`=0, target slot = `cwp`-1.
- IDLE, both requests high: `err`, no state change, no `winAddSub`.
- SPILL: drives the following until `mem_ack`:
  - `phys_raddr`=oldest*4+`k`;
  - `mem_req`=1, `mem_we`=1;
  - `mem_addr`=`spill_ptr`+`k`;
  - `mem_wdata`=`phys_rdata`.
- SPILL, on ack: `k`++. On the ack of `k`=3: `spill_ptr`+=4, `spill_cnt`++, `resident`--, go to COMMIT.
- FILL: drives `mem_req`=1, `mem_we`=0, `mem_addr`=`spill_ptr`-4+`k` until ack.
- FILL, in the ack cycle: `phys_we`=1, `phys_waddr`=target*4+`k`, `phys_wdata`=`mem_rdata`; `k`++.
- FILL, on the ack of `k`=3: `spill_ptr`-=4, `spill_cnt`--, `resident`++, go to COMMIT.
- COMMIT for one cycle, with `done`=1, then IDLE:
  - call: `winAddSub`=2'b10, `cwp`++, `resident`++;
  - return: `winAddSub`=2'b01, `cwp`--, `resident`--.
- `winAddSub` is nonzero only in COMMIT. `phys_we` is asserted only in FILL ack cycles.

## Timing
- Reset values of all outputs and state:
  - `busy`, `done`, `err`, `mem_req`, `mem_we`, `phys_we` = 0;
  - `winAddSub`=2'b00;
  - `cwp`, `resident`, `spill_cnt`, `k` = 0;
  - `spill_ptr`=`STACK_BASE`;
  - `phys_raddr`, `phys_waddr`, `mem_addr`, `mem_wdata`, `phys_wdata` = 0.
- Request sampled at edge t in IDLE, no memory traffic:
  - COMMIT during cycle t+1;
  - `reg_file` index changes at edge t+2.
- With memory traffic: 4 transfers of (1+wait) cycles each, then 1 COMMIT cycle. With zero-wait ack, a spilling call gives `done` in cycle t+5.
- `mem_req`, `mem_addr`, `mem_we` and `mem_wdata` are stable from request to ack. The next transfer's request may begin the cycle after an ack.
- `err` pulses in the cycle after the offending sample edge.
- Requests while `busy`=1 are ignored. The FSM holds each request until it sees `done` or `err`.
- Reset mid-SPILL/FILL: state is abandoned. `mem_req`=0 and `phys_we`=0 from the cycle after the reset edge. A partially spilled slot is discarded.

## Test plan
- Six calls after reset, mem idle: each `done` one cycle after IDLE sample with `winAddSub`=2'b10. Final `cwp`=6, `resident`=6, no `mem_req`.
- Seventh call (phys 0..3 preloaded 16'h1111..16'h4444):
  - 4 zero-wait writes to 16'hF000..F003 with data 1111..4444;
  - then `done`;
  - `cwp`=7, `resident`=6, `spill_cnt`=1, `spill_ptr`=16'hF004.
- Six returns, then a seventh:
  - the six need no fill, ending `resident`=0, `cwp`=1;
  - the seventh reads F000..F003 and writes phys 0..3 back to 1111..4444;
  - `cwp`=0, `spill_cnt`=0.
- An eighth return then pulses `err` with `winAddSub` held at 2'b00 and no state change.
- `mem_ack` delayed 3 cycles per transfer: `mem_req`, `mem_addr` and `mem_wdata` are constant across the wait. Total spill latency is 16+1 cycles.
- `call_req` and `ret_req` high together in IDLE: `err` pulses one cycle, and `cwp`, `resident`, `winAddSub` are unchanged.
- `reset` at `k`=2 of a spill: next cycle `mem_req`=0, `busy`=0, counters at reset values, `spill_ptr`=16'hF000.
